mem_arbiter: RTL and testbench

Two-requester memory arbiter sharing the single BRAM AXI-lite master port between the instruction-fetch requester (read-only) and the load/store requester (read or write). It sits between the `risc_v` control unit and the BRAM controller. It serialises one transaction at a time, applies round-robin arbitration, and returns an error code on a bus error or when the slave stops responding.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 66 ++++++
 rtl/mem_arbiter_rr_arbiter2.sv | 31 +++
 rtl/mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM arbiter.
package mem_arb_pkg;

  // Transaction phases of the shared AXI-lite master port
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_B,
    ST_RESP
  } arb_state_t;

  // Requester identity; doubles as the index into per-requester registers
  typedef logic req_id_t;

  localparam req_id_t REQ_IFU = 1'b0;
  localparam req_id_t REQ_LSU = 1'b1;

  // Response codes returned to the requesters
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // SLVERR/DECERR (bresp 2 or 3) collapse to a single bus-error code
  function automatic logic [1:0] bresp_to_err(input logic [1:0] bresp);
    return (bresp > 2'd1) ? ERR_BUS : ERR_OK;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundles around the arbiter: a read-only requester port (fetch),
// a read/write requester port (load/store) and the AXI-lite master port.

// Read-only requester: master = requester, slave = arbiter
interface mem_rd_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr;
  logic              resp_valid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        resp_err;

  modport master (output req_valid, addr,
                  input  req_ready, resp_valid, rdata, resp_err);
  modport slave  (input  req_valid, addr,
                  output req_ready, resp_valid, rdata, resp_err);
endinterface

// Read/write requester: master = requester, slave = arbiter
interface mem_rw_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        resp_err;

  modport master (output req_valid, we, addr, wdata,
                  input  req_ready, resp_valid, rdata, resp_err);
  modport slave  (input  req_valid, we, addr, wdata,
                  output req_ready, resp_valid, rdata, resp_err);
endinterface

// AXI-lite subset used by the BRAM controller (no wready: AW and W travel together)
interface axil_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic              wvalid;
  logic [DATA_W-1:0] wdata;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;

  modport master (output araddr, arvalid, rready, awaddr, awvalid, wvalid, wdata, bready,
                  input  arready, rvalid, rdata, awready, bvalid, bresp);
  modport slave  (input  araddr, arvalid, rready, awaddr, awvalid, wvalid, wdata, bready,
                  output arready, rvalid, rdata, awready, bvalid, bresp);
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a last-served register.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_t last_reg;

  // On a tie the requester that was not served last wins; a lone requester always wins
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_reg == REQ_LSU) ? 2'b01 : 2'b10;
    end
  end

  // Remember who was served; reset favours the fetch side on the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_reg <= REQ_LSU;
    end else if (accept) begin
      last_reg <= grant[REQ_LSU] ? REQ_LSU : REQ_IFU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto one AXI-lite BRAM port,
// one transaction at a time, with per-phase timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  mem_rd_if.slave  ifu,
  mem_rw_if.slave  lsu,
  axil_if.master   axi
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state_reg;
  req_id_t           owner_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  logic              arvalid_reg;
  logic              rready_reg;
  logic              awvalid_reg;
  logic              wvalid_reg;
  logic              bready_reg;
  logic [ADDR_W-1:0] araddr_reg;
  logic [ADDR_W-1:0] awaddr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic [1:0]        resp_valid_reg;
  logic [DATA_W-1:0] rdata_reg [2];
  logic [1:0]        err_reg   [2];

  logic [1:0]        req_valid;
  logic [1:0]        grant;
  logic              in_idle;
  logic              accept;
  logic              sel_lsu;
  logic [ADDR_W-1:0] sel_addr;

  logic              fin;
  logic              fin_load;
  logic [1:0]        fin_err;

  assign req_valid = {lsu.req_valid, ifu.req_valid};
  assign in_idle   = (state_reg == ST_IDLE) && rst;
  assign accept    = in_idle && (|req_valid);
  assign sel_lsu   = grant[REQ_LSU];
  assign sel_addr  = sel_lsu ? lsu.addr : ifu.addr;

  assign ifu.req_ready = in_idle && grant[REQ_IFU];
  assign lsu.req_ready = in_idle && grant[REQ_LSU];

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // The counter value after this cycle; aborting when it reaches TIMEOUT keeps
  // a stalled phase's valid/ready high for exactly TIMEOUT cycles
  assign cnt_inc     = cnt_reg + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  // Decode whether the current phase ends the transaction, and with what code
  always_comb begin
    fin      = 1'b0;
    fin_load = 1'b0;
    fin_err  = ERR_OK;
    unique case (state_reg)
      ST_AR: begin
        if (!axi.arready && timeout_hit) begin
          fin     = 1'b1;
          fin_err = ERR_TIMEOUT;
        end
      end
      ST_R: begin
        if (axi.rvalid) begin
          fin      = 1'b1;
          fin_load = 1'b1;
        end else if (timeout_hit) begin
          fin     = 1'b1;
          fin_err = ERR_TIMEOUT;
        end
      end
      ST_AW: begin
        if (!axi.awready && timeout_hit) begin
          fin     = 1'b1;
          fin_err = ERR_TIMEOUT;
        end
      end
      ST_B: begin
        if (axi.bvalid) begin
          fin     = 1'b1;
          fin_err = bresp_to_err(axi.bresp);
        end else if (timeout_hit) begin
          fin     = 1'b1;
          fin_err = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM with all bus and response outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      owner_reg       <= REQ_IFU;
      cnt_reg         <= '0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      araddr_reg      <= '0;
      awaddr_reg      <= '0;
      wdata_reg       <= '0;
      resp_valid_reg  <= '0;
      rdata_reg[REQ_IFU] <= '0;
      rdata_reg[REQ_LSU] <= '0;
      err_reg[REQ_IFU]   <= ERR_OK;
      err_reg[REQ_LSU]   <= ERR_OK;
    end else begin
      resp_valid_reg <= '0;
      unique case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            owner_reg <= sel_lsu ? REQ_LSU : REQ_IFU;
            cnt_reg   <= '0;
            if (sel_lsu && lsu.we) begin
              state_reg   <= ST_AW;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              awaddr_reg  <= lsu.addr;
              wdata_reg   <= lsu.wdata;
            end else begin
              state_reg   <= ST_AR;
              arvalid_reg <= 1'b1;
              araddr_reg  <= sel_addr;
            end
          end
        end
        ST_AR: begin
          if (axi.arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= ST_R;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        ST_AW: begin
          if (axi.awready) begin
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= ST_B;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        ST_R, ST_B: begin
          cnt_reg <= cnt_inc;
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase

      // Completion or abort: close every channel and pulse the owner's response
      if (fin) begin
        state_reg                 <= ST_RESP;
        arvalid_reg               <= 1'b0;
        rready_reg                <= 1'b0;
        awvalid_reg               <= 1'b0;
        wvalid_reg                <= 1'b0;
        bready_reg                <= 1'b0;
        resp_valid_reg[owner_reg] <= 1'b1;
        err_reg[owner_reg]        <= fin_err;
        if (fin_load) begin
          rdata_reg[owner_reg] <= axi.rdata;
        end
      end
    end
  end

  assign axi.arvalid = arvalid_reg;
  assign axi.araddr  = araddr_reg;
  assign axi.rready  = rready_reg;
  assign axi.awvalid = awvalid_reg;
  assign axi.awaddr  = awaddr_reg;
  assign axi.wvalid  = wvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.bready  = bready_reg;

  assign ifu.resp_valid = resp_valid_reg[REQ_IFU];
  assign ifu.rdata      = rdata_reg[REQ_IFU];
  assign ifu.resp_err   = err_reg[REQ_IFU];
  assign lsu.resp_valid = resp_valid_reg[REQ_LSU];
  assign lsu.rdata      = rdata_reg[REQ_LSU];
  assign lsu.resp_err   = err_reg[REQ_LSU];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, round-robin ties, delayed write
// with bus error, phase timeout and reset abort.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_rd_if #(.ADDR_W(20), .DATA_W(32)) ifu_bus ();
  mem_rw_if #(.ADDR_W(20), .DATA_W(32)) lsu_bus ();
  axil_if   #(.ADDR_W(20), .DATA_W(32)) axi_bus ();

  mem_arbiter #(
    .ADDR_W  (20),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_bus),
    .lsu (lsu_bus),
    .axi (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ifu_ready"},  32'(ifu_bus.req_ready),  32'd0);
    chk({tag, "_lsu_ready"},  32'(lsu_bus.req_ready),  32'd0);
    chk({tag, "_arvalid"},    32'(axi_bus.arvalid),    32'd0);
    chk({tag, "_rready"},     32'(axi_bus.rready),     32'd0);
    chk({tag, "_awvalid"},    32'(axi_bus.awvalid),    32'd0);
    chk({tag, "_wvalid"},     32'(axi_bus.wvalid),     32'd0);
    chk({tag, "_bready"},     32'(axi_bus.bready),     32'd0);
    chk({tag, "_ifu_rvld"},   32'(ifu_bus.resp_valid), 32'd0);
    chk({tag, "_lsu_rvld"},   32'(lsu_bus.resp_valid), 32'd0);
    chk({tag, "_araddr"},     32'(axi_bus.araddr),     32'd0);
    chk({tag, "_awaddr"},     32'(axi_bus.awaddr),     32'd0);
    chk({tag, "_wdata"},      axi_bus.wdata,           32'd0);
    chk({tag, "_ifu_rdata"},  ifu_bus.rdata,           32'd0);
    chk({tag, "_lsu_rdata"},  lsu_bus.rdata,           32'd0);
    chk({tag, "_ifu_err"},    32'(ifu_bus.resp_err),   32'd0);
    chk({tag, "_lsu_err"},    32'(lsu_bus.resp_err),   32'd0);
  endtask

  initial begin
    rst = 1'b0;
    ifu_bus.req_valid = 1'b0; ifu_bus.addr = '0;
    lsu_bus.req_valid = 1'b0; lsu_bus.we = 1'b0; lsu_bus.addr = '0; lsu_bus.wdata = '0;
    axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rdata = '0;
    axi_bus.awready = 1'b0; axi_bus.bvalid = 1'b0; axi_bus.bresp = 2'b00;
    tick();
    tick();

    // Reset state; requests presented during reset are not accepted
    ifu_bus.req_valid = 1'b1; ifu_bus.addr = 20'h00010;
    lsu_bus.req_valid = 1'b1; lsu_bus.addr = 20'h00099;
    #1;
    chk_all_zero("reset");
    tick();
    chk("reset_hold_arvalid", 32'(axi_bus.arvalid), 32'd0);

    // Test 1: ifu read of 0x00010, zero-wait slave
    lsu_bus.req_valid = 1'b0;
    axi_bus.arready = 1'b1; axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'hDEADBEEF;
    rst = 1'b1;
    #1;
    chk("t1_c0_ifu_ready", 32'(ifu_bus.req_ready), 32'd1);
    tick();
    ifu_bus.req_valid = 1'b0;
    chk("t1_c1_arvalid", 32'(axi_bus.arvalid), 32'd1);
    chk("t1_c1_araddr",  32'(axi_bus.araddr),  32'h00010);
    chk("t1_c1_ifu_rvld", 32'(ifu_bus.resp_valid), 32'd0);
    tick();
    chk("t1_c2_rready",  32'(axi_bus.rready),  32'd1);
    chk("t1_c2_arvalid", 32'(axi_bus.arvalid), 32'd0);
    chk("t1_c2_ifu_rvld", 32'(ifu_bus.resp_valid), 32'd0);
    tick();
    chk("t1_c3_ifu_rvld", 32'(ifu_bus.resp_valid), 32'd1);
    chk("t1_c3_ifu_rdata", ifu_bus.rdata, 32'hDEADBEEF);
    chk("t1_c3_ifu_err",  32'(ifu_bus.resp_err), 32'd0);
    chk("t1_c3_lsu_rvld", 32'(lsu_bus.resp_valid), 32'd0);
    chk("t1_c3_rready",   32'(axi_bus.rready), 32'd0);
    $display("txn ifu read  addr=%h rdata=%h err=%b", 20'h00010, ifu_bus.rdata, ifu_bus.resp_err);
    tick();
    chk("t1_c4_ifu_rvld", 32'(ifu_bus.resp_valid), 32'd0);
    chk("t1_c4_ifu_rdata_hold", ifu_bus.rdata, 32'hDEADBEEF);

    // Test 2: tie right after reset -> ifu first, then lsu, then ifu again
    rst = 1'b0;
    ifu_bus.req_valid = 1'b1; ifu_bus.addr = 20'h00100;
    lsu_bus.req_valid = 1'b1; lsu_bus.we = 1'b0; lsu_bus.addr = 20'h00200;
    tick();
    chk("t2_rst_ifu_rdata", ifu_bus.rdata, 32'd0);
    rst = 1'b1;
    axi_bus.rdata = 32'h11111111;
    #1;
    chk("t2_tie1_ifu_ready", 32'(ifu_bus.req_ready), 32'd1);
    chk("t2_tie1_lsu_ready", 32'(lsu_bus.req_ready), 32'd0);
    tick();
    ifu_bus.req_valid = 1'b0;
    #1;
    chk("t2_ifu_araddr", 32'(axi_bus.araddr), 32'h00100);
    chk("t2_busy_lsu_ready", 32'(lsu_bus.req_ready), 32'd0);
    tick();
    tick();
    chk("t2_ifu_rvld",  32'(ifu_bus.resp_valid), 32'd1);
    chk("t2_ifu_rdata", ifu_bus.rdata, 32'h11111111);
    chk("t2_resp_lsu_ready", 32'(lsu_bus.req_ready), 32'd0);
    $display("txn ifu read  addr=%h rdata=%h err=%b", 20'h00100, ifu_bus.rdata, ifu_bus.resp_err);
    axi_bus.rdata = 32'h22222222;
    tick();
    #1;
    chk("t2_idle_lsu_ready", 32'(lsu_bus.req_ready), 32'd1);
    chk("t2_idle_ifu_ready", 32'(ifu_bus.req_ready), 32'd0);
    tick();
    lsu_bus.req_valid = 1'b0;
    chk("t2_lsu_araddr", 32'(axi_bus.araddr), 32'h00200);
    tick();
    tick();
    chk("t2_lsu_rvld",  32'(lsu_bus.resp_valid), 32'd1);
    chk("t2_lsu_rdata", lsu_bus.rdata, 32'h22222222);
    chk("t2_lsu_resp_ifu_rvld", 32'(ifu_bus.resp_valid), 32'd0);
    chk("t2_ifu_rdata_hold", ifu_bus.rdata, 32'h11111111);
    $display("txn lsu read  addr=%h rdata=%h err=%b", 20'h00200, lsu_bus.rdata, lsu_bus.resp_err);
    // Both present next requests during lsu's RESP cycle
    ifu_bus.req_valid = 1'b1; ifu_bus.addr = 20'h00104;
    lsu_bus.req_valid = 1'b1; lsu_bus.addr = 20'h00204;
    #1;
    chk("t2_resp_lsu_ready2", 32'(lsu_bus.req_ready), 32'd0);
    tick();
    #1;
    chk("t2_tie2_ifu_ready", 32'(ifu_bus.req_ready), 32'd1);
    chk("t2_tie2_lsu_ready", 32'(lsu_bus.req_ready), 32'd0);
    axi_bus.rdata = 32'h33333333;
    tick();
    ifu_bus.req_valid = 1'b0;
    lsu_bus.req_valid = 1'b0;
    chk("t2_tie2_araddr", 32'(axi_bus.araddr), 32'h00104);
    tick();
    tick();
    chk("t2_tie2_ifu_rvld",  32'(ifu_bus.resp_valid), 32'd1);
    chk("t2_tie2_ifu_rdata", ifu_bus.rdata, 32'h33333333);
    $display("txn ifu read  addr=%h rdata=%h err=%b", 20'h00104, ifu_bus.rdata, ifu_bus.resp_err);
    tick();

    // Test 3: lsu write, awready held low 3 cycles, bresp = SLVERR
    axi_bus.awready = 1'b0; axi_bus.bvalid = 1'b1; axi_bus.bresp = 2'b10;
    lsu_bus.req_valid = 1'b1; lsu_bus.we = 1'b1;
    lsu_bus.addr = 20'h00020; lsu_bus.wdata = 32'h12345678;
    #1;
    chk("t3_lsu_ready", 32'(lsu_bus.req_ready), 32'd1);
    tick();
    lsu_bus.req_valid = 1'b0; lsu_bus.we = 1'b0; lsu_bus.wdata = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_wait_awvalid", 32'(axi_bus.awvalid), 32'd1);
      chk("t3_wait_wvalid",  32'(axi_bus.wvalid),  32'd1);
      chk("t3_wait_awaddr",  32'(axi_bus.awaddr),  32'h00020);
      chk("t3_wait_wdata",   axi_bus.wdata,        32'h12345678);
      tick();
    end
    axi_bus.awready = 1'b1;
    chk("t3_last_awvalid", 32'(axi_bus.awvalid), 32'd1);
    tick();
    chk("t3_b_awvalid", 32'(axi_bus.awvalid), 32'd0);
    chk("t3_b_wvalid",  32'(axi_bus.wvalid),  32'd0);
    chk("t3_b_bready",  32'(axi_bus.bready),  32'd1);
    tick();
    chk("t3_lsu_rvld",  32'(lsu_bus.resp_valid), 32'd1);
    chk("t3_lsu_err",   32'(lsu_bus.resp_err),   32'b10);
    chk("t3_lsu_rdata_hold", lsu_bus.rdata, 32'h22222222);
    chk("t3_bready_drop", 32'(axi_bus.bready), 32'd0);
    $display("txn lsu write addr=%h wdata=%h err=%b", 20'h00020, 32'h12345678, lsu_bus.resp_err);
    tick();
    chk("t3_after_lsu_rvld", 32'(lsu_bus.resp_valid), 32'd0);

    // Test 4: read address phase never accepted -> timeout after 8 cycles
    axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0;
    axi_bus.awready = 1'b0; axi_bus.bvalid = 1'b0; axi_bus.bresp = 2'b00;
    ifu_bus.req_valid = 1'b1; ifu_bus.addr = 20'h00030;
    #1;
    chk("t4_ifu_ready", 32'(ifu_bus.req_ready), 32'd1);
    tick();
    ifu_bus.req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("t4_ar_arvalid", 32'(axi_bus.arvalid), 32'd1);
      chk("t4_ar_ifu_rvld", 32'(ifu_bus.resp_valid), 32'd0);
      tick();
    end
    chk("t4_to_arvalid",  32'(axi_bus.arvalid),    32'd0);
    chk("t4_to_ifu_rvld", 32'(ifu_bus.resp_valid), 32'd1);
    chk("t4_to_ifu_err",  32'(ifu_bus.resp_err),   32'b11);
    chk("t4_to_ifu_rdata_hold", ifu_bus.rdata, 32'h33333333);
    $display("txn ifu read  addr=%h timeout err=%b", 20'h00030, ifu_bus.resp_err);
    tick();
    chk("t4_after_ifu_rvld", 32'(ifu_bus.resp_valid), 32'd0);

    // Test 5: new request accepted after timeout; reset while in B aborts silently
    axi_bus.awready = 1'b1;
    lsu_bus.req_valid = 1'b1; lsu_bus.we = 1'b1;
    lsu_bus.addr = 20'h00044; lsu_bus.wdata = 32'hA5A5A5A5;
    #1;
    chk("t5_lsu_ready", 32'(lsu_bus.req_ready), 32'd1);
    tick();
    lsu_bus.req_valid = 1'b0; lsu_bus.we = 1'b0;
    chk("t5_aw_awvalid", 32'(axi_bus.awvalid), 32'd1);
    tick();
    chk("t5_b_bready", 32'(axi_bus.bready), 32'd1);
    rst = 1'b0;
    tick();
    chk_all_zero("t5_rst");
    axi_bus.bvalid = 1'b1;
    tick();
    chk("t5_rst2_lsu_rvld", 32'(lsu_bus.resp_valid), 32'd0);
    chk("t5_rst2_bready",   32'(axi_bus.bready),     32'd0);
    $display("txn lsu write addr=%h aborted by reset", 20'h00044);
    rst = 1'b1;
    axi_bus.bvalid = 1'b0;
    axi_bus.arready = 1'b1; axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'hCAFEF00D;
    lsu_bus.req_valid = 1'b1; lsu_bus.we = 1'b0; lsu_bus.addr = 20'h00050;
    #1;
    chk("t5_post_lsu_ready", 32'(lsu_bus.req_ready), 32'd1);
    tick();
    lsu_bus.req_valid = 1'b0;
    chk("t5_post_arvalid", 32'(axi_bus.arvalid), 32'd1);
    chk("t5_post_araddr",  32'(axi_bus.araddr),  32'h00050);
    tick();
    chk("t5_post_rready", 32'(axi_bus.rready), 32'd1);
    tick();
    chk("t5_post_lsu_rvld",  32'(lsu_bus.resp_valid), 32'd1);
    chk("t5_post_lsu_rdata", lsu_bus.rdata, 32'hCAFEF00D);
    chk("t5_post_lsu_err",   32'(lsu_bus.resp_err), 32'd0);
    chk("t5_post_ifu_rvld",  32'(ifu_bus.resp_valid), 32'd0);
    $display("txn lsu read  addr=%h rdata=%h err=%b", 20'h00050, lsu_bus.rdata, lsu_bus.resp_err);
    tick();
    chk("t5_post_after_rvld", 32'(lsu_bus.resp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
